// File: rtl/cpu_pkg.sv
// Shared architectural constants and types for the register file.
package cpu_pkg;
   localparam int REG_W      = 64;
   localparam int REG_DEPTH  = 32;
   localparam int REG_ADDR_W = $clog2(REG_DEPTH);
   localparam int XZR_IDX    = REG_DEPTH - 1;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [REG_W-1:0]      reg_data_t;
endpackage

// File: rtl/regfile_sb_if.sv
// Decode-stage register file bus: operand reads, writeback and issue.
interface regfile_sb_if
   import cpu_pkg::*;
#(
   parameter int WIDTH  = REG_W,
   parameter int DEPTH  = REG_DEPTH,
   parameter int NUM_RD = 2
) ();
   localparam int AW = $clog2(DEPTH);

   logic [NUM_RD-1:0][AW-1:0]    rd_addr;
   logic [NUM_RD-1:0][WIDTH-1:0] rd_data;
   logic [NUM_RD-1:0]            rd_busy;
   logic                         wr_en;
   logic [AW-1:0]                wr_addr;
   logic [WIDTH-1:0]             wr_data;
   logic                         issue_en;
   logic [AW-1:0]                issue_addr;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data,
      output issue_en, issue_addr,
      input  rd_data, rd_busy
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data,
      input  issue_en, issue_addr,
      output rd_data, rd_busy
   );
endinterface

// File: rtl/register.sv
// Single enabled storage register; holds its value while en is low.
module register #(
   parameter int WIDTH = 64
) (
   input  logic             clk,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);
   logic [WIDTH-1:0] q_d, q_q;

   always_comb begin
      q_d = q_q;
      if (en) q_d = d;
   end

   always_ff @(posedge clk) begin
      q_q <= q_d;
   end

   assign q = q_q;
endmodule

// File: rtl/regfile_sb.sv
// Multi-port register file with write-through bypass and a busy
// scoreboard for the hazard unit.
module regfile_sb
   import cpu_pkg::*;
#(
   parameter int WIDTH    = REG_W,
   parameter int DEPTH    = REG_DEPTH,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   regfile_sb_if.slave  rf
);
   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0]             mem_q [DEPTH];
   logic [WIDTH-1:0]             wr_d;
   logic [DEPTH-1:0]             busy_d, busy_q;
   logic [NUM_RD-1:0][WIDTH-1:0] rd_data_c;
   logic [NUM_RD-1:0]            rd_busy_c;

   function automatic logic is_zero(input logic [AW-1:0] a);
      return (ZERO_REG != 0) && (a == AW'(DEPTH - 1));
   endfunction

   // Reset reuses the write path: every entry loads zero.
   assign wr_d = rst_n ? rf.wr_data : '0;

   for (genvar i = 0; i < DEPTH; i++) begin : g_reg
      if ((ZERO_REG != 0) && (i == DEPTH - 1)) begin : g_xzr
         assign mem_q[i] = '0;
      end else begin : g_ent
         logic en;
         assign en = !rst_n ||
                     (rf.wr_en && (rf.wr_addr == AW'(i)));
         register #(.WIDTH(WIDTH)) u_reg (
            .clk (clk),
            .en  (en),
            .d   (wr_d),
            .q   (mem_q[i])
         );
      end
   end

   // Issue is applied after writeback so a same-cycle set wins.
   always_comb begin
      busy_d = busy_q;
      if (rf.wr_en && !is_zero(rf.wr_addr))
         busy_d[rf.wr_addr] = 1'b0;
      if (rf.issue_en && !is_zero(rf.issue_addr))
         busy_d[rf.issue_addr] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) busy_q <= '0;
      else        busy_q <= busy_d;
   end

   always_comb begin
      rd_data_c = '0;
      rd_busy_c = '0;
      for (int p = 0; p < NUM_RD; p++) begin
         logic [AW-1:0] a;
         logic          hit;
         a   = rf.rd_addr[p];
         hit = rst_n && rf.wr_en &&
               (rf.wr_addr == a) && !is_zero(a);
         if (is_zero(a))
            rd_data_c[p] = '0;
         else if (hit)
            rd_data_c[p] = rf.wr_data;
         else
            rd_data_c[p] = mem_q[a];
         rd_busy_c[p] = busy_q[a] && !hit && !is_zero(a);
      end
   end

   assign rf.rd_data = rd_data_c;
   assign rf.rd_busy = rd_busy_c;
endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb.
module tb_regfile_sb;
   import cpu_pkg::*;

   logic clk = 1'b0;
   logic rst_n;
   int   n_run  = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   regfile_sb_if #(.WIDTH(REG_W), .DEPTH(REG_DEPTH), .NUM_RD(2)) bus ();

   regfile_sb #(
      .WIDTH(REG_W), .DEPTH(REG_DEPTH), .NUM_RD(2), .ZERO_REG(1)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .rf    (bus.slave)
   );

   task automatic chk(input string tag,
                      input logic [63:0] got,
                      input logic [63:0] exp);
      n_run++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.wr_en    = 1'b0;
      bus.issue_en = 1'b0;
   endtask

   task automatic wr(input reg_addr_t a, input reg_data_t d);
      bus.wr_en   = 1'b1;
      bus.wr_addr = a;
      bus.wr_data = d;
   endtask

   task automatic iss(input reg_addr_t a);
      bus.issue_en   = 1'b1;
      bus.issue_addr = a;
   endtask

   task automatic rd(input reg_addr_t a0, input reg_addr_t a1);
      bus.rd_addr[0] = a0;
      bus.rd_addr[1] = a1;
      #1;
   endtask

   initial begin
      // 1: reset with a write pending
      rst_n = 1'b0;
      idle();
      wr(5'd3, 64'd500);
      bus.issue_addr = '0;
      rd(5'd3, 5'd0);
      step();
      step();
      chk("rst_d0", bus.rd_data[0], 64'd0);
      chk("rst_d1", bus.rd_data[1], 64'd0);
      chk("rst_busy", {62'd0, bus.rd_busy}, 64'd0);
      rst_n = 1'b1;
      idle();
      step();
      rd(5'd3, 5'd3);
      chk("rst_r3", bus.rd_data[0], 64'd0);

      // 2: write then read back on both ports
      wr(5'd5, 64'd500);
      step();
      wr(5'd6, 64'd250);
      step();
      idle();
      rd(5'd5, 5'd6);
      chk("wr_p0_r5", bus.rd_data[0], 64'd500);
      chk("wr_p1_r6", bus.rd_data[1], 64'd250);
      rd(5'd5, 5'd5);
      chk("dup_p0", bus.rd_data[0], 64'd500);
      chk("dup_p1", bus.rd_data[1], 64'd500);

      // 3: bypass with reg 7 busy beforehand
      iss(5'd7);
      step();
      idle();
      rd(5'd7, 5'd5);
      chk("byp_pre_busy", {63'd0, bus.rd_busy[0]}, 64'd1);
      wr(5'd7, 64'hDEAD);
      rd(5'd7, 5'd5);
      chk("byp_data", bus.rd_data[0], 64'hDEAD);
      chk("byp_busy", {63'd0, bus.rd_busy[0]}, 64'd0);
      chk("byp_other", bus.rd_data[1], 64'd500);
      step();
      idle();
      rd(5'd7, 5'd5);
      chk("byp_stored", bus.rd_data[0], 64'hDEAD);
      chk("byp_clr", {63'd0, bus.rd_busy[0]}, 64'd0);

      // 4: zero register ignores writes and issues
      wr(5'd31, 64'hFFFF);
      iss(5'd31);
      rd(5'd31, 5'd31);
      chk("xzr_wcyc_d", bus.rd_data[0], 64'd0);
      chk("xzr_wcyc_b", {62'd0, bus.rd_busy}, 64'd0);
      step();
      idle();
      rd(5'd31, 5'd31);
      chk("xzr_after_d", bus.rd_data[1], 64'd0);
      chk("xzr_after_b", {62'd0, bus.rd_busy}, 64'd0);

      // 5: scoreboard set, clear, simultaneous set+clear
      iss(5'd9);
      step();
      idle();
      rd(5'd9, 5'd9);
      chk("sb_set", {63'd0, bus.rd_busy[0]}, 64'd1);
      wr(5'd9, 64'd42);
      rd(5'd9, 5'd9);
      chk("sb_wb_busy", {63'd0, bus.rd_busy[0]}, 64'd0);
      chk("sb_wb_data", bus.rd_data[1], 64'd42);
      step();
      idle();
      rd(5'd9, 5'd9);
      chk("sb_cleared", {63'd0, bus.rd_busy[1]}, 64'd0);
      chk("sb_stored", bus.rd_data[0], 64'd42);
      iss(5'd9);
      wr(5'd9, 64'd43);
      step();
      idle();
      rd(5'd9, 5'd9);
      chk("sb_setwins", {63'd0, bus.rd_busy[0]}, 64'd1);
      chk("sb_setwins_d", bus.rd_data[0], 64'd43);

      // clear of a non-busy register still writes
      wr(5'd10, 64'h1234_5678_9ABC_DEF0);
      step();
      idle();
      rd(5'd10, 5'd9);
      chk("nb_data", bus.rd_data[0], 64'h1234_5678_9ABC_DEF0);
      chk("nb_busy", {63'd0, bus.rd_busy[0]}, 64'd0);

      // 6: reset mid-operation
      wr(5'd2, 64'd100);
      step();
      idle();
      iss(5'd2);
      step();
      iss(5'd4);
      step();
      idle();
      rd(5'd2, 5'd4);
      chk("mid_pre_b2", {63'd0, bus.rd_busy[0]}, 64'd1);
      chk("mid_pre_b4", {63'd0, bus.rd_busy[1]}, 64'd1);
      chk("mid_pre_d2", bus.rd_data[0], 64'd100);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      rd(5'd2, 5'd4);
      chk("mid_b2", {63'd0, bus.rd_busy[0]}, 64'd0);
      chk("mid_b4", {63'd0, bus.rd_busy[1]}, 64'd0);
      chk("mid_d2", bus.rd_data[0], 64'd0);
      rd(5'd5, 5'd9);
      chk("mid_d5", bus.rd_data[0], 64'd0);
      chk("mid_b9", {63'd0, bus.rd_busy[1]}, 64'd0);
      wr(5'd2, 64'd7);
      step();
      idle();
      rd(5'd2, 5'd4);
      chk("mid_wr7", bus.rd_data[0], 64'd7);

      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end
endmodule
